// File: rtl/ppu_mem_arbiter.sv
// ppu_mem_arbiter
//   Shares the single-port VRAM (8000-9FFF) and OAM (FE00-FE9F) macros between
//   the CPU bus, the PPU fetch port and an OAM DMA engine. A CPU write to FF46
//   starts (or restarts) a DMA_LEN-byte copy from {FF46 value, 00} into OAM.
//   The copy alternates a system-bus read cycle with an OAM write cycle.
//   CPU access is gated by PPU mode: OAM is locked in modes 2/3, VRAM in mode 3.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cpu_addr/rd/wr/wdata/rdata  CPU bus; rdata valid the cycle after cpu_rd
//   lcd_on, ppu_mode            LCDC[7] and current PPU mode (2=SCAN, 3=DRAW)
//   ppu_rd/addr/rdata           PPU fetch port; rdata valid the cycle after ppu_rd
//   dma_active                  high from the FF46 write until the last OAM write
//   sys_rd/addr/rdata           DMA source read port; rdata valid one cycle later
//   vram_addr/rd/wr/rdata       VRAM macro, 1-cycle synchronous read latency
//   oam_addr/rd/wr/rdata        OAM macro, 1-cycle synchronous read latency
//   mem_wdata                   write data shared by both macros

module ppu_mem_arbiter #(
  parameter int unsigned DMA_LEN   = 160,
  parameter int unsigned DMA_DELAY = 1,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU / MMIO bus
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  // PPU status and fetch port
  input  logic        lcd_on,
  input  logic [1:0]  ppu_mode,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  // DMA engine
  output logic        dma_active,
  output logic        sys_rd,
  output logic [15:0] sys_addr,
  input  logic [7:0]  sys_rdata,
  // VRAM macro
  output logic [12:0] vram_addr,
  output logic        vram_rd,
  output logic        vram_wr,
  input  logic [7:0]  vram_rdata,
  // OAM macro
  output logic [7:0]  oam_addr,
  output logic        oam_rd,
  output logic        oam_wr,
  input  logic [7:0]  oam_rdata,
  // shared write data
  output logic [7:0]  mem_wdata
);

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_WAIT,
    DMA_RD,
    DMA_WR
  } dma_state_e;

  // Which macro a registered read came from; steers the returned data.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_VRAM,
    SRC_OAM
  } rd_src_e;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  OAM_SIZE     = 8'hA0;
  localparam logic [7:0]  IDX_LAST     = 8'(DMA_LEN - 1);
  localparam int unsigned DLY_W        = (DMA_DELAY > 1) ? $clog2(DMA_DELAY) : 1;
  // Unused when DMA_DELAY is 0: the WAIT state is skipped entirely.
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DMA_DELAY - 1);

  // ---------------------------------------------------------------------------
  // Address decode and ownership
  // ---------------------------------------------------------------------------
  logic cpu_hit_vram, cpu_hit_oam;
  logic ppu_hit_vram, ppu_hit_oam;
  logic ppu_owns_vram, ppu_owns_oam;
  logic dma_owns_oam, dma_rd_slot, dma_wr_slot, dma_restart;
  logic cpu_vram_go, cpu_oam_go, ppu_vram_go, ppu_oam_go;

  dma_state_e       state_q, state_d;
  logic [7:0]       src_q, src_d;
  logic [7:0]       idx_q, idx_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  rd_src_e          cpu_src_q, cpu_src_d;
  rd_src_e          ppu_src_q, ppu_src_d;

  assign cpu_hit_vram = (cpu_addr[15:13] == 3'b100);
  assign cpu_hit_oam  = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] < OAM_SIZE);
  assign ppu_hit_vram = (ppu_addr[15:13] == 3'b100);
  assign ppu_hit_oam  = (ppu_addr[15:8] == 8'hFE) && (ppu_addr[7:0] < OAM_SIZE);

  // PPU locks are mode-based: the CPU is shut out for the whole mode,
  // whether or not the PPU happens to fetch in a given cycle.
  assign ppu_owns_vram = lcd_on && (ppu_mode == 2'd3);
  assign ppu_owns_oam  = lcd_on && ppu_mode[1];

  assign dma_rd_slot  = (state_q == DMA_RD);
  assign dma_wr_slot  = (state_q == DMA_WR);
  assign dma_owns_oam = dma_rd_slot || dma_wr_slot;
  assign dma_restart  = cpu_wr && (cpu_addr == DMA_REG_ADDR);
  assign dma_active   = (state_q != DMA_IDLE);

  // The PPU may still read OAM in the DMA source-read cycle, never in the
  // DMA write cycle.
  assign ppu_vram_go = ppu_rd && ppu_hit_vram && ppu_owns_vram;
  assign ppu_oam_go  = ppu_rd && ppu_hit_oam && ppu_owns_oam && !dma_wr_slot;

  // A CPU VRAM write in the DMA write cycle is dropped: mem_wdata is shared
  // and already carries the DMA byte. A simultaneous rd+wr is a write only.
  assign cpu_vram_go = cpu_hit_vram && !ppu_owns_vram &&
                       (cpu_wr ? !dma_wr_slot : cpu_rd);
  assign cpu_oam_go  = cpu_hit_oam && !ppu_owns_oam && !dma_owns_oam &&
                       (cpu_wr || cpu_rd);

  // ---------------------------------------------------------------------------
  // DMA sequencer: next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    if (dma_restart) begin
      // A new FF46 write wins from any state and abandons the byte in flight.
      src_d   = cpu_wdata;
      idx_d   = '0;
      dly_d   = '0;
      state_d = (DMA_DELAY == 0) ? DMA_RD : DMA_WAIT;
    end else begin
      unique case (state_q)
        DMA_WAIT: begin
          if (dly_q == DLY_LAST) state_d = DMA_RD;
          else                   dly_d   = dly_q + 1'b1;
        end
        DMA_RD:   state_d = DMA_WR;
        DMA_WR: begin
          if (idx_q == IDX_LAST) begin
            state_d = DMA_IDLE;
            idx_d   = '0;
          end else begin
            state_d = DMA_RD;
            idx_d   = idx_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port steering
  // ---------------------------------------------------------------------------
  always_comb begin
    vram_addr = '0;
    vram_rd   = 1'b0;
    vram_wr   = 1'b0;
    oam_addr  = '0;
    oam_rd    = 1'b0;
    oam_wr    = 1'b0;
    mem_wdata = '0;
    sys_rd    = 1'b0;
    sys_addr  = '0;
    cpu_src_d = SRC_NONE;
    ppu_src_d = SRC_NONE;

    // The restart cycle issues no DMA strobe for the abandoned byte.
    if (dma_rd_slot && !dma_restart) begin
      sys_rd   = 1'b1;
      sys_addr = {src_q, idx_q};
    end
    if (dma_wr_slot && !dma_restart) begin
      oam_wr    = 1'b1;
      oam_addr  = idx_q;
      mem_wdata = sys_rdata;
    end

    if (ppu_vram_go) begin
      vram_rd   = 1'b1;
      vram_addr = ppu_addr[12:0];
      ppu_src_d = SRC_VRAM;
    end
    if (ppu_oam_go) begin
      oam_rd    = 1'b1;
      oam_addr  = ppu_addr[7:0];
      ppu_src_d = SRC_OAM;
    end

    // The go terms above are mutually exclusive per macro, so the CPU never
    // overrides a port already claimed by the PPU or the DMA.
    if (cpu_vram_go) begin
      vram_addr = cpu_addr[12:0];
      vram_wr   = cpu_wr;
      vram_rd   = !cpu_wr;
      if (cpu_wr) mem_wdata = cpu_wdata;
      else        cpu_src_d = SRC_VRAM;
    end
    if (cpu_oam_go) begin
      oam_addr = cpu_addr[7:0];
      oam_wr   = cpu_wr;
      oam_rd   = !cpu_wr;
      if (cpu_wr) oam_wdata_sel: mem_wdata = cpu_wdata;
      else        cpu_src_d = SRC_OAM;
    end

    // Strobes and addresses partly follow the live bus inputs, so they are
    // also forced quiet while reset is asserted.
    if (!rst_n) begin
      vram_addr = '0;
      vram_rd   = 1'b0;
      vram_wr   = 1'b0;
      oam_addr  = '0;
      oam_rd    = 1'b0;
      oam_wr    = 1'b0;
      mem_wdata = '0;
      sys_rd    = 1'b0;
      sys_addr  = '0;
    end
  end

  // Read data follows the owner tag captured with the strobe, so a mode
  // change between request and data cannot misroute it.
  always_comb begin
    unique case (cpu_src_q)
      SRC_VRAM: cpu_rdata = vram_rdata;
      SRC_OAM:  cpu_rdata = oam_rdata;
      default:  cpu_rdata = OPEN_BUS;
    endcase
    unique case (ppu_src_q)
      SRC_VRAM: ppu_rdata = vram_rdata;
      SRC_OAM:  ppu_rdata = oam_rdata;
      default:  ppu_rdata = OPEN_BUS;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DMA_IDLE;
      src_q     <= '0;
      idx_q     <= '0;
      dly_q     <= '0;
      cpu_src_q <= SRC_NONE;
      ppu_src_q <= SRC_NONE;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      dly_q     <= dly_d;
      cpu_src_q <= cpu_src_d;
      ppu_src_q <= ppu_src_d;
    end
  end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// tb_ppu_mem_arbiter
//   Drives ppu_mem_arbiter with directed and randomized CPU/PPU traffic and
//   checks it against a cycle-level reference model. The model tracks the DMA
//   as "cycles since the last FF46 write" and keeps its own VRAM/OAM images;
//   the bench also emulates the two memory macros and the DMA source bus.

module tb_ppu_mem_arbiter;

  localparam int DMA_LEN = 160;
  localparam int DMA_CYC = 1 + 2 * DMA_LEN;  // WAIT cycle + RD/WR per byte

  typedef struct {
    logic [15:0] ca;
    logic        crd;
    logic        cwr;
    logic [7:0]  cwd;
    logic        lcd;
    logic [1:0]  mode;
    logic        prd;
    logic [15:0] pa;
  } req_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        lcd_on;
  logic [1:0]  ppu_mode;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        dma_active, sys_rd;
  logic [15:0] sys_addr;
  logic [7:0]  sys_rdata;
  logic [12:0] vram_addr;
  logic        vram_rd, vram_wr;
  logic [7:0]  vram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_rd, oam_wr;
  logic [7:0]  oam_rdata;
  logic [7:0]  mem_wdata;

  ppu_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .lcd_on     (lcd_on),
    .ppu_mode   (ppu_mode),
    .ppu_rd     (ppu_rd),
    .ppu_addr   (ppu_addr),
    .ppu_rdata  (ppu_rdata),
    .dma_active (dma_active),
    .sys_rd     (sys_rd),
    .sys_addr   (sys_addr),
    .sys_rdata  (sys_rdata),
    .vram_addr  (vram_addr),
    .vram_rd    (vram_rd),
    .vram_wr    (vram_wr),
    .vram_rdata (vram_rdata),
    .oam_addr   (oam_addr),
    .oam_rd     (oam_rd),
    .oam_wr     (oam_wr),
    .oam_rdata  (oam_rdata),
    .mem_wdata  (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bench-side memories and DMA source bus
  // ---------------------------------------------------------------------------
  logic [7:0] vram_mem [8192];
  logic [7:0] oam_mem  [256];
  logic       fill;

  function automatic logic [7:0] vram_init(input int i);
    return 8'(i * 37 + 11) ^ 8'(i >> 5);
  endfunction

  function automatic logic [7:0] oam_init(input int i);
    return 8'(i * 13 + 7);
  endfunction

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[15:8] ^ {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 8192; i++) vram_mem[i] <= vram_init(i);
      for (int i = 0; i < 256; i++)  oam_mem[i]  <= oam_init(i);
    end else begin
      if (vram_wr) vram_mem[vram_addr] <= mem_wdata;
      if (oam_wr)  oam_mem[oam_addr]   <= mem_wdata;
    end
    // Idle cycles return garbage so a misrouted tag cannot pass by luck.
    vram_rdata <= vram_rd ? vram_mem[vram_addr] : 8'($urandom);
    oam_rdata  <= oam_rd  ? oam_mem[oam_addr]   : 8'($urandom);
    sys_rdata  <= sys_rd  ? src_byte(sys_addr)  : 8'($urandom);
  end

  // ---------------------------------------------------------------------------
  // Reference model state and checking
  // ---------------------------------------------------------------------------
  logic [7:0] exp_vram [8192];
  logic [7:0] exp_oam  [256];
  int         k;          // cycles since last FF46 write, 0 = no DMA
  logic [7:0] dma_src;
  logic       exp_cpu_v, exp_ppu_v;
  logic [7:0] exp_cpu_d, exp_ppu_d;
  logic       obs_active;
  int         n_checks;
  int         n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic req_t idle_req(input logic lcd);
    req_t r;
    r.ca = 16'h0000; r.crd = 1'b0; r.cwr = 1'b0; r.cwd = 8'h00;
    r.lcd = lcd; r.mode = 2'd0; r.prd = 1'b0; r.pa = 16'h0000;
    return r;
  endfunction

  function automatic req_t cpu_req(input logic [15:0] a, input logic rd, input logic wr,
                                   input logic [7:0] d);
    req_t r;
    r = idle_req(1'b0);
    r.ca = a; r.crd = rd; r.cwr = wr; r.cwd = d;
    return r;
  endfunction

  function automatic logic [15:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 999);
    if (sel < 400)      return 16'h8000 + 16'($urandom_range(0, 63));
    else if (sel < 430) return 16'h9FC0 + 16'($urandom_range(0, 63));
    else if (sel < 800) return 16'hFE00 + 16'($urandom_range(0, 159));
    else if (sel < 803) return 16'hFF46;
    else if (sel < 850) return 16'hFEA0 + 16'($urandom_range(0, 95));
    else if (sel < 870) return 16'h7FFF;
    else if (sel < 890) return 16'hA000;
    else                return 16'($urandom);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.ca   = rand_addr();
    r.cwr  = ($urandom_range(0, 2) == 0);
    r.crd  = ($urandom_range(0, 1) == 0);
    r.cwd  = 8'($urandom);
    r.lcd  = ($urandom_range(0, 3) != 0);
    r.mode = 2'($urandom);
    r.prd  = ($urandom_range(0, 1) == 0);
    r.pa   = rand_addr();
    return r;
  endfunction

  // One bus cycle: check last cycle's read data, drive this cycle, predict
  // and check strobes, then update the model's memory images and DMA count.
  task automatic step(input req_t r);
    logic hv_c, ho_c, hv_p, ho_p, ppu_v, ppu_o;
    logic dma_own, dma_wr, dma_rd, restart;
    logic e_vwr, e_owr, e_srd;
    logic [12:0] e_vaddr;
    logic [7:0]  e_oaddr, e_wdata, byte_i;

    @(negedge clk);
    if (exp_cpu_v) check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_d));
    if (exp_ppu_v) check("ppu_rdata", 32'(ppu_rdata), 32'(exp_ppu_d));

    cpu_addr = r.ca; cpu_rd = r.crd; cpu_wr = r.cwr; cpu_wdata = r.cwd;
    lcd_on = r.lcd; ppu_mode = r.mode; ppu_rd = r.prd; ppu_addr = r.pa;
    #1;

    hv_c    = (r.ca >= 16'h8000) && (r.ca <= 16'h9FFF);
    ho_c    = (r.ca >= 16'hFE00) && (r.ca <= 16'hFE9F);
    hv_p    = (r.pa >= 16'h8000) && (r.pa <= 16'h9FFF);
    ho_p    = (r.pa >= 16'hFE00) && (r.pa <= 16'hFE9F);
    ppu_v   = r.lcd && (r.mode == 2'd3);
    ppu_o   = r.lcd && (r.mode >= 2'd2);
    dma_own = (k >= 2) && (k <= DMA_CYC);
    dma_wr  = dma_own && (k % 2 == 1);
    dma_rd  = dma_own && (k % 2 == 0);
    byte_i  = dma_own ? 8'((k - 2) / 2) : 8'h00;
    restart = r.cwr && (r.ca == 16'hFF46);
    e_srd   = dma_rd && !restart;
    e_vwr   = 1'b0; e_owr = 1'b0;
    e_vaddr = '0;   e_oaddr = '0; e_wdata = '0;

    exp_cpu_v = r.crd;
    exp_cpu_d = 8'hFF;
    if (r.cwr) begin
      if (hv_c && !ppu_v && !dma_wr) begin
        e_vwr = 1'b1; e_vaddr = 13'(r.ca - 16'h8000); e_wdata = r.cwd;
        exp_vram[e_vaddr] = r.cwd;
      end else if (ho_c && !ppu_o && !dma_own) begin
        e_owr = 1'b1; e_oaddr = 8'(r.ca - 16'hFE00); e_wdata = r.cwd;
        exp_oam[e_oaddr] = r.cwd;
      end
    end else if (r.crd) begin
      if (hv_c && !ppu_v)                 exp_cpu_d = exp_vram[13'(r.ca - 16'h8000)];
      else if (ho_c && !ppu_o && !dma_own) exp_cpu_d = exp_oam[8'(r.ca - 16'hFE00)];
    end

    exp_ppu_v = r.prd;
    exp_ppu_d = 8'hFF;
    if (r.prd && hv_p && ppu_v)                exp_ppu_d = exp_vram[13'(r.pa - 16'h8000)];
    else if (r.prd && ho_p && ppu_o && !dma_wr) exp_ppu_d = exp_oam[8'(r.pa - 16'hFE00)];

    if (dma_wr && !restart) begin
      e_owr = 1'b1; e_oaddr = byte_i; e_wdata = src_byte({dma_src, byte_i});
      exp_oam[byte_i] = e_wdata;
    end

    check("dma_active", 32'(dma_active), 32'(k != 0));
    check("sys_rd", 32'(sys_rd), 32'(e_srd));
    if (e_srd) check("sys_addr", 32'(sys_addr), 32'({dma_src, byte_i}));
    check("oam_wr", 32'(oam_wr), 32'(e_owr));
    if (e_owr) begin
      check("oam_addr", 32'(oam_addr), 32'(e_oaddr));
      check("oam_wdata", 32'(mem_wdata), 32'(e_wdata));
    end
    check("vram_wr", 32'(vram_wr), 32'(e_vwr));
    if (e_vwr) begin
      check("vram_addr", 32'(vram_addr), 32'(e_vaddr));
      check("vram_wdata", 32'(mem_wdata), 32'(e_wdata));
    end
    obs_active = dma_active;

    if (restart) begin
      k = 1;
      dma_src = r.cwd;
    end else if (k != 0) begin
      k = (k == DMA_CYC) ? 0 : k + 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   cnt;
    int   mism;
    req_t r;

    n_checks = 0; n_errors = 0;
    k = 0; dma_src = 8'h00;
    exp_cpu_v = 1'b0; exp_ppu_v = 1'b0; exp_cpu_d = 8'hFF; exp_ppu_d = 8'hFF;
    obs_active = 1'b0;
    for (int i = 0; i < 8192; i++) exp_vram[i] = vram_init(i);
    for (int i = 0; i < 256; i++)  exp_oam[i]  = oam_init(i);

    // Reset with live requests on the bus: every strobe must stay quiet.
    rst_n = 1'b0; fill = 1'b1;
    cpu_addr = 16'h9800; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_wdata = 8'h00;
    lcd_on = 1'b0; ppu_mode = 2'd2; ppu_rd = 1'b1; ppu_addr = 16'hFE10;
    @(posedge clk);
    @(negedge clk);
    fill = 1'b0;
    #1;
    check("rst_vram_rd", 32'(vram_rd), 32'd0);
    check("rst_vram_addr", 32'(vram_addr), 32'd0);
    check("rst_oam_rd", 32'(oam_rd), 32'd0);
    check("rst_sys_rd", 32'(sys_rd), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    check("rst_ppu_rdata", 32'(ppu_rdata), 32'hFF);
    check("rst_dma_active", 32'(dma_active), 32'd0);
    cpu_rd = 1'b0; ppu_rd = 1'b0;
    rst_n = 1'b1;

    // LCD off: CPU owns VRAM; write 9800 then read it back.
    step(cpu_req(16'h9800, 1'b0, 1'b1, 8'h5A));
    step(cpu_req(16'h9800, 1'b1, 1'b0, 8'h00));
    step(idle_req(1'b0));

    // Mode 3: same-cycle CPU and PPU VRAM reads, only the PPU is served.
    r = cpu_req(16'h8000, 1'b1, 1'b0, 8'h00);
    r.lcd = 1'b1; r.mode = 2'd3; r.prd = 1'b1; r.pa = 16'h8010;
    step(r);
    // Mode 2: CPU VRAM read and PPU OAM read served together.
    r = cpu_req(16'h8001, 1'b1, 1'b0, 8'h00);
    r.lcd = 1'b1; r.mode = 2'd2; r.prd = 1'b1; r.pa = 16'hFE9F;
    step(r);
    // Read and write together: write wins, read returns open bus.
    step(cpu_req(16'hFE03, 1'b1, 1'b1, 8'hA5));
    step(cpu_req(16'hFE03, 1'b1, 1'b0, 8'h00));
    step(idle_req(1'b0));

    // Full copy from C1xx with CPU OAM traffic blocked mid-copy.
    step(cpu_req(16'hFF46, 1'b0, 1'b1, 8'hC1));
    cnt = 0;
    for (int i = 0; i < 330; i++) begin
      if (i == 10)      step(cpu_req(16'hFE05, 1'b0, 1'b1, 8'h77));
      else if (i == 11) step(cpu_req(16'hFE05, 1'b1, 1'b0, 8'h00));
      else              step(idle_req(1'b0));
      if (obs_active) cnt++;
    end
    check("dma_len_c1", 32'(cnt), 32'd321);
    check("oam5_src", 32'(oam_mem[5]), 32'(src_byte(16'hC105)));

    // Restart at byte 40: copy re-runs from D000 for another 321 cycles.
    step(cpu_req(16'hFF46, 1'b0, 1'b1, 8'hC0));
    for (int i = 0; i < 81; i++) step(idle_req(1'b0));
    step(cpu_req(16'hFF46, 1'b0, 1'b1, 8'hD0));
    cnt = 0;
    for (int i = 0; i < 330; i++) begin
      step(idle_req(1'b0));
      if (obs_active) cnt++;
    end
    check("dma_len_restart", 32'(cnt), 32'd321);
    check("oam0_src", 32'(oam_mem[0]), 32'(src_byte(16'hD000)));
    check("oam9f_src", 32'(oam_mem[159]), 32'(src_byte(16'hD09F)));

    // Reset asserted during byte 80 of a copy from C2xx.
    step(cpu_req(16'hFF46, 1'b0, 1'b1, 8'hC2));
    for (int i = 0; i < 161; i++) step(idle_req(1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstdma_active", 32'(dma_active), 32'd0);
    check("rstdma_sys_rd", 32'(sys_rd), 32'd0);
    check("rstdma_oam_wr", 32'(oam_wr), 32'd0);
    k = 0; exp_cpu_v = 1'b0; exp_ppu_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(idle_req(1'b0));
    check("oam79_src", 32'(oam_mem[79]), 32'(src_byte(16'hC24F)));
    mism = 0;
    for (int i = 80; i < DMA_LEN; i++) if (oam_mem[i] !== exp_oam[i]) mism++;
    check("oam_tail_kept", 32'(mism), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) step(rand_req());
    for (int i = 0; i < 4; i++) step(idle_req(1'b0));

    // Final memory images.
    @(negedge clk);
    for (int i = 0; i < DMA_LEN; i++) begin
      if (oam_mem[i] !== exp_oam[i])
        check($sformatf("oam_mem[%0d]", i), 32'(oam_mem[i]), 32'(exp_oam[i]));
      else
        n_checks++;
    end
    mism = 0;
    for (int i = 0; i < 8192; i++) if (vram_mem[i] !== exp_vram[i]) mism++;
    check("vram_mem", 32'(mism), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
